// File: rtl/coram_memory_dma.sv
// DMA engine for one CoRAM memory object: moves word_size words between external
// memory and the core BRAM, split into sequential bursts of at most MAX_BURST beats.
module coram_memory_dma #(
    parameter int W_D       = 32,
    parameter int W_EXT_A   = 64,
    parameter int W_CORE_A  = 10,
    parameter int MAX_BURST = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [63:0]         ext_addr,
    input  logic [63:0]         core_addr,
    input  logic                read_enable,
    input  logic                write_enable,
    input  logic [64:0]         word_size,
    output logic                ready,
    output logic                busy,
    output logic                ext_req_valid,
    input  logic                ext_req_ready,
    output logic                ext_req_write,
    output logic [W_EXT_A-1:0]  ext_req_addr,
    output logic [8:0]          ext_req_len,
    input  logic                ext_rdata_valid,
    output logic                ext_rdata_ready,
    input  logic [W_D-1:0]      ext_rdata,
    output logic                ext_wdata_valid,
    input  logic                ext_wdata_ready,
    output logic [W_D-1:0]      ext_wdata,
    output logic [W_CORE_A-1:0] core_addr_o,
    output logic [W_D-1:0]      core_d,
    output logic                core_we,
    input  logic [W_D-1:0]      core_q
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD_DATA, S_FETCH, S_WDATA, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [W_EXT_A-1:0]  ext_q, ext_d;
    logic [W_CORE_A-1:0] ptr_q, ptr_d;
    logic [64:0]         rem_q, rem_d;
    logic [8:0]          beats_q, beats_d;
    logic                to_core_q, to_core_d;
    logic [W_D-1:0]      wdata_q, wdata_d;
    logic                wfirst_q, wfirst_d;
    logic [8:0]          burst_len;

    logic unused_core_hi;
    assign unused_core_hi = ^core_addr[63:W_CORE_A];
    generate
        if (W_EXT_A < 64) begin : g_ext_hi
            logic unused_ext_hi;
            assign unused_ext_hi = ^ext_addr[63:W_EXT_A];
        end
    endgenerate

    assign burst_len     = (rem_q < 65'(MAX_BURST)) ? rem_q[8:0] : 9'(MAX_BURST);
    assign ext_req_write = ~to_core_q;
    assign ext_req_addr  = ext_q;
    assign ext_req_len   = burst_len;
    assign core_addr_o   = ptr_q;
    assign core_d        = ext_rdata;
    // First WDATA cycle forwards the BRAM output; later cycles replay the captured copy.
    assign ext_wdata     = wfirst_q ? core_q : wdata_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            ext_q     <= '0;
            ptr_q     <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            to_core_q <= 1'b0;
            wdata_q   <= '0;
            wfirst_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ext_q     <= ext_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            beats_q   <= beats_d;
            to_core_q <= to_core_d;
            wdata_q   <= wdata_d;
            wfirst_q  <= wfirst_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ext_d           = ext_q;
        ptr_d           = ptr_q;
        rem_d           = rem_q;
        beats_d         = beats_q;
        to_core_d       = to_core_q;
        wdata_d         = wdata_q;
        wfirst_d        = wfirst_q;
        ready           = 1'b0;
        busy            = 1'b0;
        ext_req_valid   = 1'b0;
        ext_rdata_ready = 1'b0;
        ext_wdata_valid = 1'b0;
        core_we         = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
                if (read_enable || write_enable) begin
                    state_d   = S_REQ;
                    ext_d     = ext_addr[W_EXT_A-1:0];
                    ptr_d     = core_addr[W_CORE_A-1:0];
                    rem_d     = word_size;
                    to_core_d = write_enable;
                end
            end
            S_REQ: begin
                busy = 1'b1;
                // A zero-length command spends exactly this one busy cycle here.
                if (rem_q == 65'd0) begin
                    state_d = S_DONE;
                end else begin
                    ext_req_valid = 1'b1;
                    if (ext_req_ready) begin
                        ext_d   = ext_q + W_EXT_A'(burst_len);
                        rem_d   = rem_q - 65'(burst_len);
                        beats_d = burst_len;
                        state_d = to_core_q ? S_RD_DATA : S_FETCH;
                    end
                end
            end
            S_RD_DATA: begin
                busy            = 1'b1;
                ext_rdata_ready = 1'b1;
                if (ext_rdata_valid) begin
                    core_we = 1'b1;
                    ptr_d   = ptr_q + W_CORE_A'(1);
                    beats_d = beats_q - 9'd1;
                    if (beats_q == 9'd1)
                        state_d = (rem_q == 65'd0) ? S_DONE : S_REQ;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                wfirst_d = 1'b1;
                state_d  = S_WDATA;
            end
            S_WDATA: begin
                busy            = 1'b1;
                ext_wdata_valid = 1'b1;
                wfirst_d        = 1'b0;
                if (wfirst_q)
                    wdata_d = core_q;
                if (ext_wdata_ready) begin
                    ptr_d   = ptr_q + W_CORE_A'(1);
                    beats_d = beats_q - 9'd1;
                    if (beats_q == 9'd1)
                        state_d = (rem_q == 65'd0) ? S_DONE : S_REQ;
                    else
                        state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_coram_memory_dma.sv
// Bench for coram_memory_dma: behavioural BRAM and external-memory slave with random
// stalls, a burst/beat scoreboard derived from the command parameters, and literal pins.
module tb_coram_memory_dma;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [63:0] ext_addr = '0, core_addr = '0;
    logic        read_enable = 1'b0, write_enable = 1'b0;
    logic [64:0] word_size = '0;
    logic        ready, busy;
    logic        ext_req_valid, ext_req_ready, ext_req_write;
    logic [63:0] ext_req_addr;
    logic [8:0]  ext_req_len;
    logic        ext_rdata_valid, ext_rdata_ready;
    logic [31:0] ext_rdata;
    logic        ext_wdata_valid, ext_wdata_ready;
    logic [31:0] ext_wdata;
    logic [9:0]  core_addr_o;
    logic [31:0] core_d, core_q;
    logic        core_we;

    always #5 CLK = ~CLK;

    coram_memory_dma dut (
        .CLK(CLK), .RST(RST), .ext_addr(ext_addr), .core_addr(core_addr),
        .read_enable(read_enable), .write_enable(write_enable), .word_size(word_size),
        .ready(ready), .busy(busy),
        .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
        .ext_req_write(ext_req_write), .ext_req_addr(ext_req_addr), .ext_req_len(ext_req_len),
        .ext_rdata_valid(ext_rdata_valid), .ext_rdata_ready(ext_rdata_ready), .ext_rdata(ext_rdata),
        .ext_wdata_valid(ext_wdata_valid), .ext_wdata_ready(ext_wdata_ready), .ext_wdata(ext_wdata),
        .core_addr_o(core_addr_o), .core_d(core_d), .core_we(core_we), .core_q(core_q)
    );

    logic [31:0] mem [0:1023];
    always @(posedge CLK) begin
        if (core_we) mem[core_addr_o] <= core_d;
        core_q <= mem[core_addr_o];
    end

    function automatic logic [31:0] ext_word(input logic [63:0] a);
        return (a[31:0] * 32'd2654435761) ^ 32'h5A5A_A5A5;
    endfunction

    typedef struct {logic [63:0] addr; logic [8:0] len; logic wr;} req_t;
    req_t        exp_req[$];
    req_t        req_log[$];
    logic [31:0] exp_w[$];

    int vectors = 0;
    int miscompares = 0;
    int nbusy = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // External memory slave: one decision per cycle, made at the falling edge.
    int          rd_left = 0, rd_idx = 0, wr_left = 0;
    logic [63:0] rd_base = '0;
    bit          req_pend = 0, wd_pend = 0;
    req_t        req_prev;
    logic [31:0] wd_prev = '0;

    initial begin
        bit   r;
        req_t e;
        ext_req_ready = 1'b0; ext_rdata_valid = 1'b0; ext_rdata = '0; ext_wdata_ready = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                rd_left = 0; wr_left = 0; req_pend = 0; wd_pend = 0;
                ext_req_ready = 1'b0; ext_rdata_valid = 1'b0; ext_wdata_ready = 1'b0;
                continue;
            end
            chk("ready_xor_busy", ready ^ busy, 1'b1);
            if (req_pend) begin
                chk("req_held_valid", ext_req_valid, 1'b1);
                chk("req_held_addr", ext_req_addr, req_prev.addr);
                chk("req_held_len", ext_req_len, req_prev.len);
                chk("req_held_write", ext_req_write, req_prev.wr);
            end
            if (ext_req_valid) begin
                r = ($urandom_range(0, 2) != 0);
                req_prev = '{ext_req_addr, ext_req_len, ext_req_write};
                if (r) begin
                    chk("req_while_burst_open", (rd_left == 0 && wr_left == 0), 1'b1);
                    if (exp_req.size() == 0) begin
                        chk("unexpected_req", 1'b1, 1'b0);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_addr", ext_req_addr, e.addr);
                        chk("req_len", ext_req_len, e.len);
                        chk("req_write", ext_req_write, e.wr);
                    end
                    req_log.push_back(req_prev);
                    if (ext_req_write) wr_left = int'(ext_req_len);
                    else begin rd_left = int'(ext_req_len); rd_idx = 0; rd_base = ext_req_addr; end
                end
                req_pend = !r;
                ext_req_ready = r;
            end else begin
                req_pend = 0;
                ext_req_ready = 1'b0;
            end

            if (rd_left > 0) begin
                r = ($urandom_range(0, 3) != 0);
                ext_rdata_valid = r;
                ext_rdata = ext_word(rd_base + 64'(rd_idx));
                if (r && ext_rdata_ready) begin rd_idx++; rd_left--; end
            end else begin
                ext_rdata_valid = 1'b0;
            end

            if (wd_pend) begin
                chk("wdata_held_valid", ext_wdata_valid, 1'b1);
                chk("wdata_stable", ext_wdata, wd_prev);
            end
            if (ext_wdata_valid) begin
                r = ($urandom_range(0, 2) != 0);
                wd_prev = ext_wdata;
                if (r) begin
                    chk("wbeat_in_burst", wr_left > 0, 1'b1);
                    if (wr_left > 0) wr_left--;
                    if (exp_w.size() == 0) chk("unexpected_wbeat", 1'b1, 1'b0);
                    else chk("wdata", ext_wdata, exp_w.pop_front());
                end
                wd_pend = !r;
                ext_wdata_ready = r;
            end else begin
                wd_pend = 0;
                ext_wdata_ready = 1'b0;
            end
        end
    end

    task automatic expect_cmd(input bit we, input logic [63:0] ea, input logic [63:0] ca,
                              input logic [64:0] sz);
        logic [64:0] rem;
        logic [63:0] a;
        logic [8:0]  l;
        logic [9:0]  idx;
        rem = sz; a = ea;
        while (rem != 0) begin
            l = (rem > 65'd16) ? 9'd16 : rem[8:0];
            exp_req.push_back('{a, l, ~we});
            a = a + 64'(l);
            rem = rem - 65'(l);
        end
        if (!we)
            for (int k = 0; k < int'(sz); k++) begin
                idx = 10'(ca + 64'(k));
                exp_w.push_back(mem[idx]);
            end
    endtask

    task automatic run_cmd(input bit re, input bit we, input logic [63:0] ea,
                           input logic [63:0] ca, input logic [64:0] sz, input bit poke);
        int         guard;
        logic [9:0] idx;
        @(negedge CLK);
        chk("ready_before_cmd", ready, 1'b1);
        req_log.delete();
        expect_cmd(we, ea, ca, sz);
        read_enable = re; write_enable = we;
        ext_addr = ea; core_addr = ca; word_size = sz;
        @(negedge CLK);
        read_enable = 1'b0; write_enable = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        nbusy = 0; guard = 0;
        while (ready !== 1'b1 && guard < 5000) begin
            chk("busy_held", busy, 1'b1);
            nbusy++;
            if (poke) begin
                read_enable = 1'($urandom_range(0, 1));
                write_enable = 1'($urandom_range(0, 1));
                ext_addr = 64'(32'hDEAD_0000); word_size = 65'd3;
            end
            @(negedge CLK);
            guard++;
        end
        read_enable = 1'b0; write_enable = 1'b0;
        chk("cmd_timeout", guard < 5000, 1'b1);
        chk("req_remaining", exp_req.size(), 0);
        chk("wdata_remaining", exp_w.size(), 0);
        if (we)
            for (int k = 0; k < int'(sz); k++) begin
                idx = 10'(ca + 64'(k));
                chk("bram_word", mem[idx], ext_word(ea + 64'(k)));
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'hB000_0000 | 32'(k);
        repeat (3) @(negedge CLK);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_valid", ext_req_valid, 1'b0);
        chk("rst_wdata_valid", ext_wdata_valid, 1'b0);
        chk("rst_rdata_ready", ext_rdata_ready, 1'b0);
        chk("rst_core_we", core_we, 1'b0);
        RST = 1'b1;

        // 128 words external->core.
        run_cmd(1'b0, 1'b1, 64'd0, 64'd0, 65'd128, 1'b0);
        chk("t1_nreq", req_log.size(), 8);
        chk("t1_last_addr", req_log[7].addr, 64'd112);
        chk("t1_last_len", req_log[7].len, 9'd16);
        chk("t1_bram5", mem[5], ext_word(64'd5));

        // 20 words core->external.
        run_cmd(1'b1, 1'b0, 64'd16384, 64'd0, 65'd20, 1'b0);
        chk("t2_nreq", req_log.size(), 2);
        chk("t2_addr0", req_log[0].addr, 64'd16384);
        chk("t2_len0", req_log[0].len, 9'd16);
        chk("t2_write0", req_log[0].wr, 1'b1);
        chk("t2_addr1", req_log[1].addr, 64'd16400);
        chk("t2_len1", req_log[1].len, 9'd4);

        // Zero-length command.
        run_cmd(1'b1, 1'b0, 64'd77, 64'd0, 65'd0, 1'b0);
        chk("t3_busy_cycles", nbusy, 1);
        chk("t3_nreq", req_log.size(), 0);

        // Core address wrap.
        run_cmd(1'b0, 1'b1, 64'd500, 64'd1020, 65'd8, 1'b0);
        chk("t4_bram1020", mem[1020], ext_word(64'd500));
        chk("t4_bram3", mem[3], ext_word(64'd507));

        // Both enables: external->core wins; enables toggled while busy.
        run_cmd(1'b1, 1'b1, 64'd2000, 64'd300, 65'd5, 1'b1);
        chk("t5_nreq", req_log.size(), 1);
        chk("t5_write", req_log[0].wr, 1'b0);

        // External address wraps, core address wraps, core->external.
        run_cmd(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd1018, 65'd20, 1'b0);
        chk("t6_addr1", req_log[1].addr, 64'd8);
        chk("t6_len1", req_log[1].len, 9'd4);

        // Reset in the middle of a burst, then a fresh command.
        @(negedge CLK);
        req_log.delete();
        expect_cmd(1'b1, 64'd900, 64'd40, 65'd64);
        write_enable = 1'b1; ext_addr = 64'd900; core_addr = 64'd40; word_size = 65'd64;
        @(negedge CLK);
        write_enable = 1'b0;
        repeat (12) @(negedge CLK);
        chk("t7_busy_before_rst", busy, 1'b1);
        RST = 1'b0;
        @(negedge CLK);
        chk("t7_ready", ready, 1'b1);
        chk("t7_busy", busy, 1'b0);
        chk("t7_req_valid", ext_req_valid, 1'b0);
        chk("t7_wdata_valid", ext_wdata_valid, 1'b0);
        chk("t7_rdata_ready", ext_rdata_ready, 1'b0);
        exp_req.delete(); exp_w.delete();
        @(negedge CLK);
        RST = 1'b1;
        run_cmd(1'b0, 1'b1, 64'd3000, 64'd700, 65'd20, 1'b0);
        chk("t7_nreq", req_log.size(), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
